// File: rtl/fp_div_pkg.sv
// Shared FP32 field widths, result layout and flag bundle for the divide path.
// Pure declarations, no logic.
// Imported by the post-divide stage and its rounding helper.
package fp_div_pkg;

    localparam int          FP_EXP_W   = 8;
    localparam int          FP_FRAC_W  = 23;
    localparam int          FP_BIAS    = 127;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } fp32_t;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic inx;
        logic spc;
    } div_flags_t;

endpackage

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even of a quotient using the divider remainder against the divisor.
// Latency: purely combinational.
// Backpressure: none, the enclosing pipeline stage owns flow control.
module fp_rne_round #(
    parameter int N = 48
) (
    input  logic [N/2-1:0] i_quot,
    input  logic [N/2-1:0] i_rem,
    input  logic [N-1:0]   i_divisor,
    output logic [N/2:0]   o_mant,
    output logic           o_inexact
);

    logic [N:0] w_rem_x2;
    logic [N:0] w_div_x;
    logic       w_rnd_up;

    // Twice the remainder against the divisor tells whether the dropped part is above, at or below half an ulp.
    always_comb begin
        w_rem_x2  = {{(N/2){1'b0}}, i_rem, 1'b0};
        w_div_x   = {1'b0, i_divisor};
        w_rnd_up  = (w_rem_x2 > w_div_x) || ((w_rem_x2 == w_div_x) && i_quot[0]);
        o_mant    = {1'b0, i_quot} + {{(N/2){1'b0}}, w_rnd_up};
        o_inexact = |i_rem;
    end

endmodule

// File: rtl/fp_div_norm_round.sv
// Post-divide stage: rounds the quotient, adjusts exponent, saturates/flushes and packs FP32.
// Latency: 2 cycles from accept to out_valid, one result per cycle.
// Backpressure: valid/ready; a stalled output holds both stages and drops in_ready once full.
module fp_div_norm_round
    import fp_div_pkg::*;
#(
    parameter int N     = 48,
    parameter int EXP_W = 10
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N/2-1:0]          in_quot,
    input  logic [N/2-1:0]          in_rem,
    input  logic [N-1:0]            in_divisor,
    input  logic signed [EXP_W-1:0] in_exp,
    input  logic                    in_sign,
    input  logic                    in_special,
    input  logic [31:0]             in_spec_val,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_result,
    output logic [3:0]              out_flags
);

    logic             r_s1_vld;
    logic [N/2:0]     r_s1_mant;
    logic             r_s1_inx;
    logic             r_s1_nz;
    logic [EXP_W-1:0] r_s1_exp;
    logic             r_s1_sign;
    logic             r_s1_spc;
    logic [31:0]      r_s1_spec_val;

    logic             r_s2_vld;
    fp32_t            r_s2_res;
    div_flags_t       r_s2_flags;

    logic             w_s1_adv;
    logic [N/2:0]     w_mant;
    logic             w_inexact;
    logic             w_carry;
    logic [EXP_W:0]   w_exp_adj;
    logic             w_ovf;
    logic             w_unf;
    fp32_t            w_res;
    div_flags_t       w_flags;

    assign w_s1_adv   = !r_s2_vld || out_ready;
    assign in_ready   = !r_s1_vld || w_s1_adv;
    assign out_valid  = r_s2_vld;
    assign out_result = r_s2_res;
    assign out_flags  = r_s2_flags;

    fp_rne_round #(.N(N)) u_round (
        .i_quot    (in_quot),
        .i_rem     (in_rem),
        .i_divisor (in_divisor),
        .o_mant    (w_mant),
        .o_inexact (w_inexact)
    );

    // Stage 1 captures the rounded mantissa and side-band; it empties when it hands off and nothing new arrives.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_vld      <= 1'b0;
            r_s1_mant     <= '0;
            r_s1_inx      <= 1'b0;
            r_s1_nz       <= 1'b0;
            r_s1_exp      <= '0;
            r_s1_sign     <= 1'b0;
            r_s1_spc      <= 1'b0;
            r_s1_spec_val <= '0;
        end else begin
            if (in_ready) begin
                r_s1_vld <= in_valid;
            end
            if (in_valid && in_ready) begin
                r_s1_mant     <= w_mant;
                r_s1_inx      <= w_inexact;
                r_s1_nz       <= (|in_rem) || (|in_quot);
                r_s1_exp      <= in_exp;
                r_s1_sign     <= in_sign;
                r_s1_spc      <= in_special;
                r_s1_spec_val <= in_spec_val;
            end
        end
    end

    // Rounding carry-out renormalises by bumping the exponent; the result then saturates to inf or flushes to zero.
    always_comb begin
        w_carry   = r_s1_mant[N/2];
        w_exp_adj = {r_s1_exp[EXP_W-1], r_s1_exp} + {{EXP_W{1'b0}}, w_carry};
        w_ovf     = !w_exp_adj[EXP_W] && (w_exp_adj[EXP_W-1:0] >= EXP_W'(FP_EXP_MAX));
        w_unf     = w_exp_adj[EXP_W] || (w_exp_adj == '0);

        w_res.sign = r_s1_sign;
        w_res.exp  = w_exp_adj[FP_EXP_W-1:0];
        w_res.frac = w_carry ? '0 : r_s1_mant[FP_FRAC_W-1:0];
        w_flags    = '{ovf: 1'b0, unf: 1'b0, inx: r_s1_inx, spc: 1'b0};

        if (r_s1_spc) begin
            w_res   = r_s1_spec_val;
            w_flags = '{ovf: 1'b0, unf: 1'b0, inx: 1'b0, spc: 1'b1};
        end else if (w_ovf) begin
            w_res   = {r_s1_sign, FP_EXP_MAX, {FP_FRAC_W{1'b0}}};
            w_flags = '{ovf: 1'b1, unf: 1'b0, inx: 1'b1, spc: 1'b0};
        end else if (w_unf) begin
            w_res   = {r_s1_sign, 31'h0};
            w_flags = '{ovf: 1'b0, unf: 1'b1, inx: r_s1_nz, spc: 1'b0};
        end
    end

    // Stage 2 is the output register; it only changes when the consumer can take it or it is empty.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s2_vld   <= 1'b0;
            r_s2_res   <= '0;
            r_s2_flags <= '0;
        end else if (w_s1_adv) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_res   <= w_res;
                r_s2_flags <= w_flags;
            end
        end
    end

endmodule

// File: tb/tb_fp_div_norm_round.sv
// Randomised and directed checks of the post-divide stage against an arithmetic reference model.
// Expected results are queued at accept time and popped by an independent output monitor.
// Output ready is stalled on purpose to exercise hold, full-pipe and reset-flush behaviour.
module tb_fp_div_norm_round;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_quot = '0;
    logic [23:0] in_rem = '0;
    logic [47:0] in_divisor = '0;
    logic signed [9:0] in_exp = '0;
    logic        in_sign = 1'b0;
    logic        in_special = 1'b0;
    logic [31:0] in_spec_val = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    int errs = 0;
    int checks = 0;
    bit rand_done = 0;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    fp_div_norm_round #(.N(48), .EXP_W(10)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_quot    (in_quot),
        .in_rem     (in_rem),
        .in_divisor (in_divisor),
        .in_exp     (in_exp),
        .in_sign    (in_sign),
        .in_special (in_special),
        .in_spec_val(in_spec_val),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: exact comparison of the dropped fraction against half an ulp, then range check.
    function automatic exp_t model(input logic [23:0] q, input logic [23:0] r, input logic [47:0] m,
                                   input int e_in, input bit s, input bit spc, input logic [31:0] sv);
        exp_t o;
        longint unsigned qq, r2, mm;
        int e;
        if (spc) begin
            o.res = sv;
            o.fl  = 4'b0001;
            return o;
        end
        e  = e_in;
        qq = q;
        r2 = 2 * longint'(r);
        mm = m;
        if (r2 > mm || (r2 == mm && (qq % 2) == 1)) qq = qq + 1;
        if (qq >= 64'd16777216) begin
            qq = qq / 2;
            e  = e + 1;
        end
        if (e >= 255) begin
            o.res = {s, 8'hFF, 23'h0};
            o.fl  = 4'b1010;
        end else if (e <= 0) begin
            o.res = {s, 31'h0};
            o.fl  = {2'b01, (r != 0) || (q != 0), 1'b0};
        end else begin
            o.res = {s, 8'(e), 23'(qq - 64'd8388608)};
            o.fl  = {2'b00, r != 0, 1'b0};
        end
        return o;
    endfunction

    // Caller is just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [23:0] q, input logic [23:0] r, input logic [47:0] m, input int e,
                        input bit s, input bit spc, input logic [31:0] sv, input exp_t ex);
        int waitc = 0;
        in_quot = q; in_rem = r; in_divisor = m; in_exp = 10'(e);
        in_sign = s; in_special = spc; in_spec_val = sv; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            errs++; checks++;
            $display("FAIL accept_timeout: in_ready stayed 0 expected 1");
        end else begin
            sb_q.push_back(ex);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [23:0] q, input logic [23:0] r, input logic [47:0] m, input int e,
                          input bit s, input bit spc, input logic [31:0] sv);
        send(q, r, m, e, s, spc, sv, model(q, r, m, e, s, spc, sv));
    endtask

    task automatic send_d(input logic [23:0] q, input logic [23:0] r, input logic [47:0] m, input int e,
                          input bit s, input logic [31:0] res, input logic [3:0] fl);
        exp_t ex;
        ex.res = res; ex.fl = fl;
        send(q, r, m, e, s, 1'b0, 32'h0, ex);
    endtask

    // Output monitor: scoreboard pop on transfer, and stability of a stalled output.
    initial begin
        logic [31:0] prev_res;
        logic [3:0]  prev_fl;
        bit held;
        exp_t ex;
        held = 0; prev_res = '0; prev_fl = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                held = 0;
            end else begin
                if (held) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_result", 64'(out_result), 64'(prev_res));
                    chk("hold_flags", 64'(out_flags), 64'(prev_fl));
                end
                held = out_valid && !out_ready;
                prev_res = out_result;
                prev_fl  = out_flags;
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        errs++; checks++;
                        $display("FAIL unexpected_output: got %h with nothing expected", out_result);
                    end else begin
                        ex = sb_q.pop_front();
                        chk("result", 64'(out_result), 64'(ex.res));
                        chk("flags", 64'(out_flags), 64'(ex.fl));
                    end
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_out_flags", 64'(out_flags), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Directed cases
        send_d(24'hC00000, 24'h0, 48'h800000, 127, 0, 32'h3FC00000, 4'b0000);
        send_d(24'h800000, 24'h400000, 48'h800000, 127, 0, 32'h3F800000, 4'b0010);
        send_d(24'h800001, 24'h400000, 48'h800000, 127, 0, 32'h3F800002, 4'b0010);
        send_d(24'hFFFFFF, 24'h7FFFFF, 48'h800000, 127, 0, 32'h40000000, 4'b0010);
        send_d(24'h800000, 24'h0, 48'h800000, 255, 1, 32'hFF800000, 4'b1010);
        send_d(24'h800000, 24'h0, 48'h800000, 0, 1, 32'h80000000, 4'b0110);
        begin
            exp_t ex;
            ex.res = 32'h7FC00000; ex.fl = 4'b0001;
            send(24'h123456, 24'h000077, 48'h800000, 127, 0, 1'b1, 32'h7FC00000, ex);
        end
        repeat (4) @(posedge clk); #1;

        // Backpressure: two accepts fill the pipe, third waits while output is held
        out_ready = 1'b0;
        send_d(24'hA00000, 24'h0, 48'h800000, 130, 0, 32'h41200000, 4'b0000);
        send_d(24'hB00000, 24'h0, 48'h800000, 131, 1, 32'hC1B00000, 4'b0000);
        @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        fork
            send_d(24'hE00000, 24'h1, 48'h800000, 100, 0, 32'h32600000, 4'b0010);
            begin
                repeat (5) @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk); #1;

        // Reset with two results in flight
        out_ready = 1'b0;
        send_d(24'h900000, 24'h0, 48'h800000, 127, 0, 32'h3F900000, 4'b0000);
        send_d(24'h910000, 24'h0, 48'h800000, 127, 0, 32'h3F910000, 4'b0000);
        rstn = 1'b0;
        #1;
        chk("rstmid_out_valid", 64'(out_valid), 64'd0);
        sb_q.delete();
        out_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rstmid_no_output", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;

        // Random traffic with random output stalls
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    logic [23:0] q, r;
                    logic [47:0] m;
                    int e, mode;
                    bit s, spc;
                    q = 24'($urandom) | 24'h800000;
                    mode = $urandom_range(0, 3);
                    if (mode == 0) begin
                        m = 48'($urandom_range(24'h800000, 24'hFFFFFF));
                        r = 24'($urandom % 32'(m));
                    end else if (mode == 1) begin
                        m = 48'($urandom_range(24'h400000, 24'h7FFFFF)) << 1;
                        r = 24'(m >> 1);
                    end else if (mode == 2) begin
                        m = 48'($urandom) & 48'h3FFFFFF;
                        r = 24'($urandom);
                    end else begin
                        m = 48'h800000;
                        r = 24'($urandom_range(0, 3)) << 21;
                    end
                    e = $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 20)) - 10
                        : ($urandom_range(0, 9) == 0 ? int'($urandom_range(245, 300)) : int'($urandom_range(1, 254)));
                    s = 1'($urandom);
                    spc = ($urandom_range(0, 9) == 0);
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk); #1;
                    end
                    send_m(q, r, m, e, s, spc, $urandom);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join

        // Drain
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        chk("idle_out_valid", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
